// File: rtl/matrix_add_row_ctrl.sv
// matrix_add_row_ctrl
// Sequencing stage around an external combinational per-lane adder set.
// Pairs A and B rows arriving on independent valid/ready streams, presents
// the registered pair to the adder set, captures the returned sum and streams
// the sum rows out with valid/ready. done pulses after ROW_NUM rows.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start                 begin a matrix (sampled in IDLE only)
//   aValid/aReady/aRowSet A row stream (16 bit x PARALLEL_NUM lanes)
//   bValid/bReady/bRowSet B row stream
//   addaSet/addbSet       registered operands to the adder set
//   addabSet              combinational sum from the adder set
//   sumValid/sumReady/sumRowSet/sumRowIdx  result stream and row number
//   busy                  high outside IDLE
//   done                  one-cycle pulse at end of matrix
//   ovf                   sticky lane-overflow flag (MATRIX_ADD_SAT_EN only)
//
// Build option: define MATRIX_ADD_SAT_EN for signed saturating lanes and the
// ovf port; otherwise lane sums wrap modulo 2^16.
module matrix_add_row_ctrl #(
    parameter int unsigned PARALLEL_NUM = 28,
    parameter int unsigned ROW_NUM      = 28,
    parameter int unsigned IDX_W        = $clog2(ROW_NUM)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        aValid,
    output logic                        aReady,
    input  logic [16*PARALLEL_NUM-1:0]  aRowSet,
    input  logic                        bValid,
    output logic                        bReady,
    input  logic [16*PARALLEL_NUM-1:0]  bRowSet,
    output logic [16*PARALLEL_NUM-1:0]  addaSet,
    output logic [16*PARALLEL_NUM-1:0]  addbSet,
    input  logic [16*PARALLEL_NUM-1:0]  addabSet,
    output logic                        sumValid,
    input  logic                        sumReady,
    output logic [16*PARALLEL_NUM-1:0]  sumRowSet,
    output logic [IDX_W-1:0]            sumRowIdx,
    output logic                        busy,
    output logic                        done
`ifdef MATRIX_ADD_SAT_EN
    ,
    output logic                        ovf
`endif
);

    localparam int unsigned LANE_W = 16;
    localparam int unsigned ROW_W  = LANE_W * PARALLEL_NUM;
    localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(ROW_NUM - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ADD,
        OUT,
        DONE
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] row_cnt;
    logic             a_have;
    logic             b_have;
    logic             a_fire;
    logic             b_fire;
    logic [ROW_W-1:0] sum_next;
`ifdef MATRIX_ADD_SAT_EN
    logic             lane_ovf_any;
`endif

    // Ready is only ever high in LOAD, so these are LOAD handshakes.
    assign a_fire = aValid && aReady;
    assign b_fire = bValid && bReady;

    // Value captured into sumRowSet during ADD.
    always_comb begin
        sum_next = addabSet;
`ifdef MATRIX_ADD_SAT_EN
        lane_ovf_any = 1'b0;
        // Signed overflow: operands share a sign that the raw sum does not.
        for (int unsigned i = 0; i < PARALLEL_NUM; i++) begin
            if ((addaSet[LANE_W*i + (LANE_W-1)] == addbSet[LANE_W*i + (LANE_W-1)]) &&
                (addabSet[LANE_W*i + (LANE_W-1)] != addaSet[LANE_W*i + (LANE_W-1)])) begin
                lane_ovf_any = 1'b1;
                sum_next[LANE_W*i +: LANE_W] =
                    addaSet[LANE_W*i + (LANE_W-1)] ? 16'h8000 : 16'h7FFF;
            end
        end
`endif
    end

    // Row sequencer; all outputs are registered and updated with next-state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            row_cnt   <= '0;
            a_have    <= 1'b0;
            b_have    <= 1'b0;
            addaSet   <= '0;
            addbSet   <= '0;
            sumRowSet <= '0;
            sumRowIdx <= '0;
            aReady    <= 1'b0;
            bReady    <= 1'b0;
            sumValid  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef MATRIX_ADD_SAT_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        row_cnt <= '0;
                        a_have  <= 1'b0;
                        b_have  <= 1'b0;
                        aReady  <= 1'b1;
                        bReady  <= 1'b1;
                        busy    <= 1'b1;
                        state   <= LOAD;
`ifdef MATRIX_ADD_SAT_EN
                        ovf     <= 1'b0;
`endif
                    end
                end
                LOAD: begin
                    if (a_fire) begin
                        addaSet <= aRowSet;
                        a_have  <= 1'b1;
                        aReady  <= 1'b0;
                    end
                    if (b_fire) begin
                        addbSet <= bRowSet;
                        b_have  <= 1'b1;
                        bReady  <= 1'b0;
                    end
                    // Leave on the edge that completes the pair.
                    if ((a_have || a_fire) && (b_have || b_fire)) begin
                        aReady <= 1'b0;
                        bReady <= 1'b0;
                        state  <= ADD;
                    end
                end
                ADD: begin
                    sumRowSet <= sum_next;
                    sumRowIdx <= row_cnt;
                    sumValid  <= 1'b1;
                    state     <= OUT;
`ifdef MATRIX_ADD_SAT_EN
                    if (lane_ovf_any) begin
                        ovf <= 1'b1;
                    end
`endif
                end
                OUT: begin
                    if (sumReady) begin
                        sumValid <= 1'b0;
                        a_have   <= 1'b0;
                        b_have   <= 1'b0;
                        if (row_cnt == LAST_ROW) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            row_cnt <= row_cnt + IDX_W'(1);
                            aReady  <= 1'b1;
                            bReady  <= 1'b1;
                            state   <= LOAD;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/matrix_add_row_ctrl.md
# matrix_add_row_ctrl

Sequencing stage wrapped around the combinational per-lane adder set (PARALLEL_NUM lanes of 16 bit). It accepts matrix A and matrix B one row at a time on two independent valid/ready streams and pairs the rows. It drives the paired operands, already registered, into the adder set's `addaSet`/`addbSet`, and captures the returned `addabSet` into an output register. The captured sum rows are streamed downstream with valid/ready, and `done` pulses after ROW_NUM rows.

## Interface
- `PARALLEL_NUM`, 28: lanes per row; each lane is 16 bit.
- `ROW_NUM`, 28: rows per matrix; must be ≥ 2.
- `IDX_W`, `$clog2(ROW_NUM)`: width of the row index.

- `clk` input 1: the single clock; all logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: begins a matrix; sampled only in IDLE.
- `aValid` input 1, `aReady` output 1, `aRowSet` input 16*PARALLEL_NUM: A row stream.
- `bValid` input 1, `bReady` output 1, `bRowSet` input 16*PARALLEL_NUM: B row stream.
- `addaSet` output 16*PARALLEL_NUM: registered A row, driven to the adder set.
- `addbSet` output 16*PARALLEL_NUM: registered B row, driven to the adder set.
- `addabSet` input 16*PARALLEL_NUM: combinational sum returned by the adder set.
- `sumValid` output 1, `sumReady` input 1, `sumRowSet` output 16*PARALLEL_NUM: result stream.
- `sumRowIdx` output IDX_W: row number of the current `sumRowSet`.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse at the end of a matrix.
- `ovf` output 1: sticky lane-overflow flag; exists only with the macro (see Configuration).

## Operation
- FSM states: IDLE, LOAD, ADD, OUT, DONE.
- **IDLE**
  - When `start`=1, clear `rowCnt`, `aHave`, `bHave` and `ovf`, then go to LOAD.
  - `start` in any other state is ignored.
- **LOAD**
  - `aReady` = !aHave and `bReady` = !bHave.
  - An A handshake (aValid && aReady) loads `aRowSet` into the A register and sets `aHave`. B behaves identically and independently.
  - Both streams may handshake in the same cycle.
  - When aHave && bHave, go to ADD.
- **ADD**
  - Lasts exactly one cycle.
  - `sumRowSet` <= `addabSet` per lane (modified per lane with the macro, see Configuration).
  - `sumRowIdx` <= rowCnt.
  - Next state is OUT.
- **OUT**
  - `sumValid` = 1, and `sumRowSet`/`sumRowIdx` are held stable until `sumReady`.
  - On the handshake, clear aHave and bHave.
  - If rowCnt == ROW_NUM-1, go to DONE; otherwise increment rowCnt and go to LOAD.
- **DONE**
  - `done` = 1 for this single cycle, then go to IDLE.
- `aReady`/`bReady` are 0 in IDLE, ADD, OUT and DONE. Input rows offered during those states are not consumed.
- `addaSet`/`addbSet` always show the A/B registers and are stable from the LOAD→ADD transition through the ADD cycle.
- Arithmetic is lane-wise 16-bit. There is no carry between lanes. Lane i occupies bits [16i+15:16i].
- Without the macro, a lane sum wraps modulo 2^16 (0xFFFF + 0x0001 = 0x0000).
- Reset mid-operation:
  - The FSM returns to IDLE.
  - All outputs and registers return to their reset values.
  - A partially transferred matrix is discarded.

## Timing
- Reset values: `aReady`=0, `bReady`=0, `sumValid`=0, `busy`=0, `done`=0, `ovf`=0. `addaSet`, `addbSet`, `sumRowSet` and `sumRowIdx` are all 0.
- `start` sampled at edge T → `busy`=1 and LOAD from cycle T+1.
- The last operand handshake at edge T → ADD in cycle T+1 → `sumValid`=1 from cycle T+2.
- Minimum cycles per row, with both streams always valid and `sumReady` always high:
  - 3 cycles: LOAD, ADD, OUT.
  - A full matrix takes ROW_NUM*3 + 1 (DONE) cycles after `start`.
- The `sumReady` handshake at edge T:
  - Not the last row: `sumValid`=0 and LOAD in cycle T+1.
  - Last row: `done`=1 in cycle T+1, and IDLE with `busy`=0 in cycle T+2.
- `start` asserted in the `done` cycle is ignored. A new `start` is accepted from IDLE only.

## Configuration
- Macro `MATRIX_ADD_SAT_EN`, when defined:
  - Lanes are treated as signed two's complement.
  - Overflow in lane i is detected when A[i] and B[i] have the same sign and addab[i] has the opposite sign.
  - An overflowing lane is captured as 0x7FFF if A[i] is positive, or 0x8000 if A[i] is negative.
  - Port `ovf` is present. It is set on any lane overflow during ADD and stays set until `rst` or the next accepted `start`.
- When `MATRIX_ADD_SAT_EN` is undefined:
  - The adder set's result is captured raw (wrap-around).
  - Port `ovf` is absent.

## Test plan
- Reset mid-OUT: `rst` while `sumValid`=1 → next cycle all outputs are 0 and state is IDLE. A following `start` runs a complete new matrix from row 0.
- Streaming: ROW_NUM=4, PARALLEL_NUM=28, A lane i = i, B lane i = 0x0100, all valid, `sumReady`=1 → four rows with lane i = 0x0100+i and `sumRowIdx` 0..3. `done` pulses 13 cycles after the `start` edge.
- Skewed operands: A arrives 5 cycles before B → `aReady` drops after the A handshake. ADD occurs 1 cycle after the B handshake. A second A row offered meanwhile is not accepted.
- Backpressure: `sumReady`=0 for 10 cycles in OUT → `sumRowSet`, `sumRowIdx` and `sumValid` are held. `aReady`/`bReady` stay 0 and rowCnt does not advance.
- Wrap vs saturate: lane0 0x7FFF+0x0001, lane1 0xFFFF+0x0001 →
  - without the macro: 0x8000 and 0x0000;
  - with `MATRIX_ADD_SAT_EN`: 0x7FFF and 0x0000, with `ovf`=1 until the next `start`.
- Ignored start: `start` held high through a whole matrix → exactly one matrix is processed, with no restart during LOAD, ADD, OUT or DONE.
